// File: rtl/qam_pulse_shaper_if.sv
// Bus bundle for one axis of the 64-QAM pulse shaper: symbol input
// handshake, upsampling rate, coefficient write port and filtered output.
//
// Handshake: a symbol transfers on a rising clk edge where both sym_valid
// and sym_ready are high. The source must hold sym_in stable while
// sym_valid is high and ready is low. sym_ready never depends
// combinationally on sym_valid. valid_data has no back-pressure: the sink
// must take data_filter on every cycle where valid_data is high.
interface qam_pulse_shaper_if #(
    parameter int NUM_TAPS = 32,
    parameter int SYM_W    = 4,
    parameter int COEF_W   = 12,
    parameter int OUT_W    = 12
);
    localparam int ADDR_W = $clog2(NUM_TAPS);

    logic signed [SYM_W-1:0]  sym_in;
    logic                     sym_valid;
    logic                     sym_ready;
    logic [8:0]               upsampling_rate;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [OUT_W-1:0]  data_filter;
    logic                     valid_data;

    // Mapper / control side
    modport master (
        output sym_in, sym_valid, upsampling_rate, coef_we, coef_addr, coef_data,
        input  sym_ready, data_filter, valid_data
    );

    // Pulse shaper side
    modport slave (
        input  sym_in, sym_valid, upsampling_rate, coef_we, coef_addr, coef_data,
        output sym_ready, data_filter, valid_data
    );
endinterface

// File: rtl/qam_pulse_shaper.sv
// Interpolating pulse-shaping FIR for one QAM axis. Each accepted symbol is
// zero-stuffed to R samples (R latched at acceptance), pushed through a
// NUM_TAPS delay line and filtered with runtime-loadable coefficients.
// Output appears exactly two edges after each delay-line shift.
module qam_pulse_shaper #(
    parameter int NUM_TAPS = 32,
    parameter int SYM_W    = 4,
    parameter int COEF_W   = 12,
    parameter int OUT_W    = 12,
    parameter int SHIFT    = 6
) (
    input logic               clk,
    input logic               rst,
    qam_pulse_shaper_if.slave bus
);
    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int PROD_W = SYM_W + COEF_W;
    localparam int ACC_W  = PROD_W + ADDR_W;
    // One guard bit so adding the rounding constant can never wrap.
    localparam int RND_W  = ACC_W + 1;

    localparam logic [8:0]               RATE_ONE   = 9'd1;
    localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(2 ** SHIFT);
    localparam logic signed [RND_W-1:0]  ROUND_HALF = RND_W'(2 ** (SHIFT - 1));
    localparam logic signed [RND_W-1:0]  OUT_MAX    = RND_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [RND_W-1:0]  OUT_MIN    = ~OUT_MAX;

    // Upsampler: cnt counts samples emitted for the current symbol, rate_l
    // is the rate latched when that symbol was accepted. cnt == rate_l is
    // the done/idle condition and doubles as sym_ready.
    logic [8:0] cnt;
    logic [8:0] rate_l;
    logic [8:0] rate_eff;
    logic       fire;
    logic       shift;

    logic signed [SYM_W-1:0]  dline [NUM_TAPS];
    logic signed [COEF_W-1:0] coef  [NUM_TAPS];
    logic signed [PROD_W-1:0] prod  [NUM_TAPS];

    // v_shift: delay line was updated at the last edge.
    // v_prod:  products of that delay line are registered.
    logic v_shift;
    logic v_prod;

    logic signed [ACC_W-1:0] acc;
    logic signed [RND_W-1:0] rnd;
    logic signed [RND_W-1:0] scaled;
    logic signed [OUT_W-1:0] y;

    logic signed [OUT_W-1:0] data_q;
    logic                    valid_q;

    assign rate_eff      = (bus.upsampling_rate == '0) ? RATE_ONE : bus.upsampling_rate;
    assign bus.sym_ready = (cnt == rate_l);
    assign fire          = bus.sym_valid & bus.sym_ready;
    // A new symbol or a pending stuffed zero both advance the delay line;
    // otherwise the line is held (underflow stall).
    assign shift         = fire | (cnt < rate_l);

    // Sample counter and rate latch; rate changes mid-symbol are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= RATE_ONE;
            rate_l <= RATE_ONE;
        end else if (fire) begin
            cnt    <= RATE_ONE;
            rate_l <= rate_eff;
        end else if (cnt < rate_l) begin
            cnt    <= cnt + 9'd1;
        end
    end

    // Delay line: newest sample at index 0, symbol on fire, zero otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                dline[k] <= '0;
            end
        end else if (shift) begin
            dline[0] <= fire ? bus.sym_in : '0;
            for (int k = 1; k < NUM_TAPS; k++) begin
                dline[k] <= dline[k-1];
            end
        end
    end

    // Coefficient bank: impulse on reset, single-tap writes otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                coef[k] <= (k == 0) ? COEF_UNITY : '0;
            end
        end else if (bus.coef_we) begin
            coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    // Per-tap product register; each product fits exactly in PROD_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                prod[k] <= PROD_W'(dline[k]) * PROD_W'(coef[k]);
            end
        end
    end

    // Pipeline valid tracking for the two stages after a shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_shift <= 1'b0;
            v_prod  <= 1'b0;
        end else begin
            v_shift <= shift;
            v_prod  <= v_shift;
        end
    end

    // Adder tree, round half up, arithmetic shift and saturation.
    always_comb begin
        acc = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc = acc + ACC_W'(prod[k]);
        end
        rnd    = RND_W'(acc) + ROUND_HALF;
        scaled = rnd >>> SHIFT;
        if (scaled > OUT_MAX) begin
            y = OUT_W'(OUT_MAX);
        end else if (scaled < OUT_MIN) begin
            y = OUT_W'(OUT_MIN);
        end else begin
            y = OUT_W'(scaled);
        end
    end

    // Output register: data holds its last value while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= v_prod;
            if (v_prod) begin
                data_q <= y;
            end
        end
    end

    assign bus.data_filter = data_q;
    assign bus.valid_data  = valid_q;
endmodule

// File: tb/tb_qam_pulse_shaper.sv
// Bench for qam_pulse_shaper: directed scenarios plus randomized symbols,
// rates, gaps and coefficients, checked against a convolution model of the
// zero-stuffed symbol stream.
module tb_qam_pulse_shaper;
    localparam int NUM_TAPS = 32;
    localparam int SYM_W    = 4;
    localparam int COEF_W   = 12;
    localparam int OUT_W    = 12;
    localparam int SHIFT    = 6;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    qam_pulse_shaper_if #(
        .NUM_TAPS(NUM_TAPS), .SYM_W(SYM_W), .COEF_W(COEF_W), .OUT_W(OUT_W)
    ) bus ();

    qam_pulse_shaper #(
        .NUM_TAPS(NUM_TAPS), .SYM_W(SYM_W), .COEF_W(COEF_W), .OUT_W(OUT_W), .SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [OUT_W-1:0] exp_q[$];
    int               exp_cyc_q[$];
    int               hist[$];
    int               m_coef[NUM_TAPS];
    int               last_val = 0;
    logic [OUT_W-1:0] mon_val;
    int               mon_cyc;

    function automatic void check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference model: y[n] = sum_k coef[k] * x[n-k], rounded half up by
    // 2^SHIFT and clipped to the output range.
    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < NUM_TAPS; k++) m_coef[k] = 0;
        m_coef[0] = 2 ** SHIFT;
        exp_q.delete();
        exp_cyc_q.delete();
    endfunction

    function automatic void model_sample(int s, int at_cyc);
        int sum;
        int yv;
        hist.push_front(s);
        if (hist.size() > NUM_TAPS) void'(hist.pop_back());
        sum = 0;
        for (int k = 0; k < hist.size(); k++) sum += m_coef[k] * hist[k];
        yv = (sum + 2 ** (SHIFT - 1)) >>> SHIFT;
        if (yv > 2 ** (OUT_W - 1) - 1) yv = 2 ** (OUT_W - 1) - 1;
        if (yv < -(2 ** (OUT_W - 1)))  yv = -(2 ** (OUT_W - 1));
        exp_q.push_back(OUT_W'(yv));
        exp_cyc_q.push_back(at_cyc);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.valid_data === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: data_filter=%0d at cycle %0d, no sample required",
                         $signed(bus.data_filter), cyc);
            end else begin
                mon_val = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                check("sample_value", $signed(bus.data_filter), $signed(mon_val));
                check("sample_cycle", cyc, mon_cyc);
                last_val = $signed(bus.data_filter);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_reset(input logic with_write);
        @(negedge clk);
        #1;
        rst = 1'b1;
        bus.sym_valid = 1'b0;
        if (with_write) begin
            bus.coef_we   = 1'b1;
            bus.coef_addr = '0;
            bus.coef_data = 12'sd100;
        end
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        bus.coef_we = 1'b0;
    endtask

    task automatic write_coef(input int a, input int d);
        bus.coef_we   = 1'b1;
        bus.coef_addr = a[4:0];
        bus.coef_data = d[11:0];
        @(negedge clk);
        bus.coef_we = 1'b0;
        m_coef[a] = d;
    endtask

    // Present one symbol until it is accepted; returns the acceptance edge.
    task automatic send_sym(input int s, input int rate, output int fire_cyc);
        int guard;
        int r_eff;
        guard = 0;
        bus.sym_in          = s[3:0];
        bus.sym_valid       = 1'b1;
        bus.upsampling_rate = rate[8:0];
        while (bus.sym_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) begin
            check("ready_timeout", guard, 0);
            fire_cyc = cyc;
        end else begin
            @(negedge clk);
            fire_cyc = cyc;
            r_eff = (rate == 0) ? 1 : rate;
            for (int i = 0; i < r_eff; i++) model_sample((i == 0) ? s : 0, fire_cyc + i + 2);
        end
    endtask

    task automatic idle(input int n);
        bus.sym_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int g;
        g = 0;
        bus.sym_valid = 1'b0;
        while (exp_q.size() > 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) begin
            check("drain_left", exp_q.size(), 0);
            exp_q.delete();
            exp_cyc_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    int f1, f2, f3, f4;
    int levels[8] = '{-7, -5, -3, -1, 1, 3, 5, 7};

    initial begin
        bus.sym_in          = '0;
        bus.sym_valid       = 1'b0;
        bus.upsampling_rate = 9'd1;
        bus.coef_we         = 1'b0;
        bus.coef_addr       = '0;
        bus.coef_data       = '0;
        model_reset();
        repeat (2) @(negedge clk);

        // 1: reset values, impulse, R=1 continuous
        apply_reset(1'b0);
        check("rst_valid", int'(bus.valid_data), 0);
        check("rst_data", $signed(bus.data_filter), 0);
        check("rst_ready", int'(bus.sym_ready), 1);
        send_sym(7, 1, f1);
        send_sym(-7, 1, f2);
        send_sym(3, 1, f3);
        drain();
        check("r1_interval_a", f2 - f1, 1);
        check("r1_interval_b", f3 - f2, 1);
        check("r1_last", last_val, 3);

        // 2: R=4 back-to-back; rate 2 presented while -1 is mid-symbol
        send_sym(5, 4, f1);
        send_sym(-1, 4, f2);
        send_sym(3, 2, f3);
        send_sym(1, 2, f4);
        drain();
        check("r4_interval_a", f2 - f1, 4);
        check("r4_interval_b", f3 - f2, 4);
        check("r2_interval", f4 - f3, 2);

        // 3: four unity taps, single symbol then underflow stall
        apply_reset(1'b0);
        for (int k = 1; k < 4; k++) write_coef(k, 64);
        send_sym(3, 4, f1);
        drain();
        check("hold_last", last_val, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", int'(bus.valid_data), 0);
        end
        check("stall_data_hold", $signed(bus.data_filter), 3);

        // 4: saturation both ways
        apply_reset(1'b0);
        for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 2047);
        for (int i = 0; i < 40; i++) send_sym(7, 1, f1);
        drain();
        check("sat_pos", last_val, 2047);
        for (int i = 0; i < 40; i++) send_sym(-7, 1, f1);
        drain();
        check("sat_neg", last_val, -2048);

        // 5: rounding half up
        apply_reset(1'b0);
        write_coef(0, 32);
        send_sym(1, 1, f1);
        drain();
        check("round_pos", last_val, 1);
        send_sym(-1, 1, f1);
        drain();
        check("round_neg", last_val, 0);

        // 6: reset mid-symbol (with a coefficient write that must lose)
        send_sym(7, 8, f1);
        idle(3);
        apply_reset(1'b1);
        check("mid_rst_valid", int'(bus.valid_data), 0);
        check("mid_rst_data", $signed(bus.data_filter), 0);
        check("mid_rst_ready", int'(bus.sym_ready), 1);
        send_sym(7, 1, f1);
        drain();
        check("post_rst_impulse", last_val, 7);

        // Randomized: symbols, rates (incl. 0), gaps, coefficient sets
        apply_reset(1'b0);
        for (int round = 0; round < 4; round++) begin
            for (int j = 0; j < 6; j++) begin
                int d;
                d = int'($urandom_range(0, 4095));
                if (d >= 2048) d -= 4096;
                write_coef(int'($urandom_range(0, NUM_TAPS - 1)), d);
            end
            for (int i = 0; i < 25; i++) begin
                send_sym(levels[$urandom_range(0, 7)], int'($urandom_range(0, 5)), f1);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
            end
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog: the run is far shorter than this in normal operation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time %0t exceeded, cycle %0d", $time, cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
